// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a ripple slice,
// with the carry between digits held in a register. Start/done handshake.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [DIGIT-1:0] sum;
        logic             c_msb;   // carry into the top bit of the slice
        logic             c_out;   // carry out of the top bit of the slice
    } slice_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    slice_t             slice;
    logic [WIDTH-1:0]   acc_next;

    function automatic slice_t add_digit(input logic [DIGIT-1:0] x,
                                         input logic [DIGIT-1:0] y,
                                         input logic             ci);
        slice_t r;
        logic   c;
        r = '0;
        c = ci;
        for (int i = 0; i < DIGIT; i++) begin
            r.c_msb  = c;
            r.sum[i] = x[i] ^ y[i] ^ c;
            c        = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        r.c_out = c;
        return r;
    endfunction

    always_comb begin
        slice = add_digit(op_a_q[DIGIT-1:0], op_b_q[DIGIT-1:0], carry_q);
        // New digit enters at the MSB end; works unchanged when DIGIT == WIDTH.
        acc_next = WIDTH'({slice.sum, acc_q} >> DIGIT);
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                op_a_d  = op_a_q >> DIGIT;
                op_b_d  = op_b_q >> DIGIT;
                carry_d = slice.c_out;
                acc_d   = acc_next;
                cnt_d   = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    // Publish on the edge that enters DONE so outputs align with done.
                    state_d  = S_DONE;
                    result_d = acc_next;
                    cout_d   = slice.c_out;
                    ovf_d    = slice.c_out ^ slice.c_msb;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: three instances (DIGIT 4, 1, 16),
// directed vectors on the DIGIT=4 instance, then a random sweep on all three.
module tb_serial_add_sub;

    localparam int W  = 16;
    localparam int NI = 3;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           k;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst    [NI];
    logic         start  [NI];
    logic         sub    [NI];
    logic         cin    [NI];
    logic [W-1:0] a      [NI];
    logic [W-1:0] b      [NI];
    logic         busy   [NI];
    logic         done   [NI];
    logic [W-1:0] result [NI];
    logic         cout   [NI];
    logic         ovf    [NI];

    exp_t exp_q [NI][$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s [dut%0d]: got 0x%0h, expected 0x%0h", name, idx, act, req);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D  = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        localparam int NC = W / D;
        exp_t e;

        serial_add_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk    (clk),
            .rst    (rst[g]),
            .start  (start[g]),
            .sub    (sub[g]),
            .a      (a[g]),
            .b      (b[g]),
            .cin    (cin[g]),
            .busy   (busy[g]),
            .done   (done[g]),
            .result (result[g]),
            .cout   (cout[g]),
            .ovf    (ovf[g])
        );

        always @(negedge clk) begin
            if (done[g] === 1'b1) begin
                if (exp_q[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done [dut%0d]: got done=1 at cycle %0d, expected no done", g, cyc);
                end else begin
                    e = exp_q[g].pop_front();
                    check("result", g, 32'(result[g]), 32'(e.res));
                    check("cout", g, 32'(cout[g]), 32'(e.co));
                    check("ovf", g, 32'(ovf[g]), 32'(e.ov));
                    check("latency", g, cyc - e.k, NC);
                    check("busy_with_done", g, 32'(busy[g]), 32'd0);
                end
            end
        end
    end

    task automatic issue(input int idx, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic s, input logic ci, input bit push,
                         input logic [W-1:0] er, input logic eco, input logic eov);
        exp_t e;
        @(negedge clk);
        a[idx]     = av;
        b[idx]     = bv;
        sub[idx]   = s;
        cin[idx]   = ci;
        start[idx] = 1'b1;
        if (push) begin
            e.res = er;
            e.co  = eco;
            e.ov  = eov;
            e.k   = cyc + 1;
            exp_q[idx].push_back(e);
        end
        @(negedge clk);
        start[idx] = 1'b0;
        a[idx]     = ~av;
        b[idx]     = ~bv;
        sub[idx]   = ~s;
        cin[idx]   = ~ci;
    endtask

    task automatic wait_idle(input int idx);
        int n = 0;
        while ((exp_q[idx].size() != 0 || busy[idx] || done[idx]) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout [dut%0d]: got %0d pending, expected 0", idx, exp_q[idx].size());
            exp_q[idx].delete();
        end
    endtask

    task automatic issue_rand(input int idx);
        logic [W-1:0] av, bv, eb, er;
        logic         s, ci, eov;
        logic [W:0]   full;
        av   = W'($urandom);
        bv   = W'($urandom);
        s    = 1'($urandom);
        ci   = 1'($urandom);
        eb   = s ? ~bv : bv;
        full = {1'b0, av} + {1'b0, eb} + (W+1)'(ci);
        er   = full[W-1:0];
        eov  = (av[W-1] == eb[W-1]) && (er[W-1] != av[W-1]);
        issue(idx, av, bv, s, ci, 1'b1, er, full[W], eov);
    endtask

    task automatic run_sweep(input int idx, input int count);
        for (int i = 0; i < count; i++) begin
            issue_rand(idx);
            wait_idle(idx);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i]   = 1'b1;
            start[i] = 1'b0;
            sub[i]   = 1'b0;
            cin[i]   = 1'b0;
            a[i]     = '0;
            b[i]     = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", 0, 32'(busy[0]), 32'd0);
        check("rst_done", 0, 32'(done[0]), 32'd0);
        check("rst_result", 0, 32'(result[0]), 32'd0);
        check("rst_cout", 0, 32'(cout[0]), 32'd0);
        check("rst_ovf", 0, 32'(ovf[0]), 32'd0);
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 0, 32'(busy[0]), 32'd0);

        // Plain add, subtract with borrow, and both overflow directions.
        issue(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b0);
        wait_idle(0);
        issue(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        wait_idle(0);
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        wait_idle(0);
        issue(0, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        wait_idle(0);

        // A start pulse in RUN cycle 2 must be ignored.
        issue(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        @(negedge clk);
        check("busy_run2", 0, 32'(busy[0]), 32'd1);
        a[0] = 16'h1111;
        b[0] = 16'h2222;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_idle(0);
        repeat (10) @(negedge clk);

        // Start held during DONE chains a second operation.
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done[0] !== 1'b1 && n < 50);
            if (n >= 50) begin
                checks++;
                errors++;
                $display("FAIL b2b_done_timeout [dut0]: got no done, expected done");
            end
        end
        begin
            exp_t e2;
            a[0]     = 16'h1000;
            b[0]     = 16'h0001;
            sub[0]   = 1'b1;
            cin[0]   = 1'b1;
            start[0] = 1'b1;
            e2.res = 16'h0FFF;
            e2.co  = 1'b1;
            e2.ov  = 1'b0;
            e2.k   = cyc + 1;
            exp_q[0].push_back(e2);
        end
        @(negedge clk);
        start[0] = 1'b0;
        check("b2b_busy", 0, 32'(busy[0]), 32'd1);
        check("b2b_done_low", 0, 32'(done[0]), 32'd0);
        wait_idle(0);

        // Reset in RUN cycle 2 aborts with no done; a later op completes.
        issue(0, 16'h4321, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        check("abort_busy", 0, 32'(busy[0]), 32'd0);
        check("abort_result", 0, 32'(result[0]), 32'd0);
        check("abort_done", 0, 32'(done[0]), 32'd0);
        rst[0] = 1'b0;
        repeat (8) @(negedge clk);
        issue(0, 16'hAAAA, 16'h5555, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        wait_idle(0);

        fork
            run_sweep(0, 1000);
            run_sweep(1, 1000);
            run_sweep(2, 1000);
        join

        repeat (5) @(negedge clk);
        for (int i = 0; i < NI; i++) check("queue_empty", i, exp_q[i].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
